// File: rtl/simple_edge_detect_pkg.sv
// Shared constants, pattern helpers and FSM encoding for the edge-detect pattern checker.
package simple_edge_detect_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RUN_W  = 4;

    localparam logic [DATA_W-1:0] PAT_0 = 8'h81;
    localparam logic [DATA_W-1:0] PAT_1 = 8'h42;
    localparam logic [DATA_W-1:0] PAT_2 = 8'h24;
    localparam logic [DATA_W-1:0] PAT_3 = 8'h18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_e;

    // Successor in the rotating sequence; anything unknown restarts at PAT_0.
    function automatic logic [DATA_W-1:0] next_pattern(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] n;
        case (x)
            PAT_0:   n = PAT_1;
            PAT_1:   n = PAT_2;
            PAT_2:   n = PAT_3;
            PAT_3:   n = PAT_0;
            default: n = PAT_0;
        endcase
        return n;
    endfunction

    function automatic logic is_pattern(input logic [DATA_W-1:0] x);
        return (x == PAT_0) || (x == PAT_1) || (x == PAT_2) || (x == PAT_3);
    endfunction

endpackage

// File: rtl/simple_edge_detect_checker_edge_toggle_sync.sv
// Synchronizes an asynchronous toggle strobe and emits a one-cycle pulse on either edge.
module edge_toggle_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic toggle_i,
    output logic pulse_c_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rising and falling edges of the strobe are both significant.
    assign pulse_c_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/simple_edge_detect_checker.sv
// Receive-side checker: captures data on each strobe edge, tracks the rotating
// pattern sequence and keeps saturating match/error counts.
module simple_edge_detect_checker
    import simple_edge_detect_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_LOSS   = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] captureData,
    input  logic              captureEdge,
    input  logic              enable,
    input  logic              clearCounters,
    output logic [DATA_W-1:0] latchedData,
    output logic              dataValid,
    output logic              locked,
    output logic [CNT_W-1:0]  matchCount,
    output logic [CNT_W-1:0]  errorCount,
    output logic [DATA_W-1:0] mismatchData
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   latched_q, latched_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    match_q, match_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [DATA_W-1:0]   mism_q, mism_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                pulse_c;
    logic                capture_c;
    logic                match_inc_c;
    logic                err_inc_c;

    edge_toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .toggle_i  (captureEdge),
        .pulse_c_o (pulse_c)
    );

    assign capture_c = pulse_c & enable;

    // Next-state, capture and pattern tracking.
    always_comb begin
        state_d     = state_q;
        data_d      = captureData;
        latched_d   = latched_q;
        valid_d     = 1'b0;
        mism_d      = mism_q;
        exp_d       = exp_q;
        run_d       = run_q;
        match_inc_c = 1'b0;
        err_inc_c   = 1'b0;

        if (capture_c) begin
            latched_d = data_q;
            valid_d   = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (capture_c && is_pattern(data_q)) begin
                    exp_d   = next_pattern(data_q);
                    run_d   = '0;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (capture_c) begin
                    exp_d = next_pattern(data_q);
                    if (data_q == exp_q) begin
                        match_inc_c = 1'b1;
                        run_d       = '0;
                    end else begin
                        err_inc_c = 1'b1;
                        mism_d    = data_q;
                        if (run_q == RUN_W'(LOCK_LOSS - 1)) begin
                            run_d   = '0;
                            state_d = ACQUIRE;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d = IDLE;
            run_d   = '0;
        end
    end

    // Saturating counters; a clear overrides a same-cycle increment.
    always_comb begin
        match_d = match_q;
        err_d   = err_q;
        if (clearCounters) begin
            match_d = '0;
            err_d   = '0;
        end else begin
            if (match_inc_c && (match_q != '1)) match_d = match_q + CNT_W'(1);
            if (err_inc_c && (err_q != '1))     err_d   = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            latched_q <= '0;
            valid_q   <= 1'b0;
            match_q   <= '0;
            err_q     <= '0;
            mism_q    <= '0;
            exp_q     <= PAT_0;
            run_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            latched_q <= latched_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            err_q     <= err_d;
            mism_q    <= mism_d;
            exp_q     <= exp_d;
            run_q     <= run_d;
        end
    end

    assign latchedData  = latched_q;
    assign dataValid    = valid_q;
    assign locked       = (state_q == TRACK);
    assign matchCount   = match_q;
    assign errorCount   = err_q;
    assign mismatchData = mism_q;

endmodule

// File: tb/tb_simple_edge_detect_checker.sv
// Directed bench for simple_edge_detect_checker; a second narrow-counter instance covers saturation.
module tb_simple_edge_detect_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  captureData;
    logic        captureEdge;
    logic        enable;
    logic        clearCounters;

    logic [7:0]  latchedData, latchedData2;
    logic        dataValid, dataValid2;
    logic        locked, locked2;
    logic [15:0] matchCount, errorCount;
    logic [1:0]  matchCount2, errorCount2;
    logic [7:0]  mismatchData, mismatchData2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    simple_edge_detect_checker #(
        .SYNC_STAGES (2),
        .LOCK_LOSS   (4),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .captureData   (captureData),
        .captureEdge   (captureEdge),
        .enable        (enable),
        .clearCounters (clearCounters),
        .latchedData   (latchedData),
        .dataValid     (dataValid),
        .locked        (locked),
        .matchCount    (matchCount),
        .errorCount    (errorCount),
        .mismatchData  (mismatchData)
    );

    simple_edge_detect_checker #(
        .SYNC_STAGES (2),
        .LOCK_LOSS   (4),
        .CNT_W       (2)
    ) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .captureData   (captureData),
        .captureEdge   (captureEdge),
        .enable        (enable),
        .clearCounters (clearCounters),
        .latchedData   (latchedData2),
        .dataValid     (dataValid2),
        .locked        (locked2),
        .matchCount    (matchCount2),
        .errorCount    (errorCount2),
        .mismatchData  (mismatchData2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Toggle the strobe with new data; capture lands on the third clk edge after the first sample.
    task automatic send(input logic [7:0] d, input logic clr);
        @(negedge clk);
        captureData = d;
        captureEdge = ~captureEdge;
        @(negedge clk);
        @(negedge clk);
        check("valid_early", 32'(dataValid), 32'd0);
        clearCounters = clr;
        @(negedge clk);
        clearCounters = 1'b0;
        check("valid_pulse", 32'(dataValid), 32'd1);
        check("latched", 32'(latchedData), 32'(d));
        @(negedge clk);
        check("valid_single", 32'(dataValid), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_latched"}, 32'(latchedData), 32'h00);
        check({tag, "_valid"}, 32'(dataValid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_match"}, 32'(matchCount), 32'd0);
        check({tag, "_err"}, 32'(errorCount), 32'd0);
        check({tag, "_mism"}, 32'(mismatchData), 32'h00);
    endtask

    initial begin
        reset         = 1'b1;
        captureData   = 8'h55;
        captureEdge   = 1'b0;
        enable        = 1'b0;
        clearCounters = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");

        // Acquire: the generator reset value is ignored, then lock on 0x81.
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        send(8'h55, 1'b0);
        check("acq_ignore_locked", 32'(locked), 32'd0);
        check("acq_ignore_match", 32'(matchCount), 32'd0);
        send(8'h81, 1'b0);
        check("lock_after_81", 32'(locked), 32'd1);
        check("lock_no_count", 32'(matchCount), 32'd0);
        send(8'h42, 1'b0);
        send(8'h24, 1'b0);
        send(8'h18, 1'b0);
        check("seq_match", 32'(matchCount), 32'd3);
        check("seq_err", 32'(errorCount), 32'd0);

        // Single mismatch with resync.
        send(8'h81, 1'b0);
        send(8'h42, 1'b0);
        send(8'h18, 1'b0);
        check("mm_err", 32'(errorCount), 32'd1);
        check("mm_data", 32'(mismatchData), 32'h18);
        check("mm_locked", 32'(locked), 32'd1);
        send(8'h81, 1'b0);
        check("resync_match", 32'(matchCount), 32'd6);
        check("resync_err", 32'(errorCount), 32'd1);
        check("resync_locked", 32'(locked), 32'd1);

        // Four consecutive mismatches drop lock.
        for (int i = 0; i < 4; i++) begin
            send(8'h81, 1'b0);
            check("loss_locked", 32'(locked), (i < 3) ? 32'd1 : 32'd0);
        end
        check("loss_err", 32'(errorCount), 32'd5);
        check("loss_mism", 32'(mismatchData), 32'h81);
        check("loss_match", 32'(matchCount), 32'd6);
        send(8'h81, 1'b0);
        check("relock", 32'(locked), 32'd1);
        check("relock_match", 32'(matchCount), 32'd6);

        // Narrow counters saturate instead of wrapping (6 matches, 5 errors so far).
        check("sat_match", 32'(matchCount2), 32'd3);
        check("sat_err", 32'(errorCount2), 32'd3);

        // Clear coinciding with a match: clear wins.
        send(8'h42, 1'b1);
        check("clr_match", 32'(matchCount), 32'd0);
        check("clr_err", 32'(errorCount), 32'd0);
        check("clr_sat_match", 32'(matchCount2), 32'd0);
        send(8'h24, 1'b0);
        check("post_clr_match", 32'(matchCount), 32'd1);
        check("post_clr_sat", 32'(matchCount2), 32'd1);

        // Strobe toggles while disabled are discarded.
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_locked", 32'(locked), 32'd0);
        captureData = 8'h18;
        captureEdge = ~captureEdge;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("dis_no_valid", 32'(dataValid), 32'd0);
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en_no_spurious", 32'(dataValid), 32'd0);
        end
        check("dis_latched", 32'(latchedData), 32'h24);
        check("dis_match", 32'(matchCount), 32'd1);
        check("dis_err", 32'(errorCount), 32'd0);
        send(8'h18, 1'b0);
        check("reen_locked", 32'(locked), 32'd1);
        check("reen_match", 32'(matchCount), 32'd1);
        send(8'h81, 1'b0);
        check("reen_track", 32'(matchCount), 32'd2);

        // Mid-run reset restores everything.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check_reset_state("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
